// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply job arbiter.
package matmul_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RUN,
    ARB_RELEASE,
    ARB_ABORT
  } arb_state_t;

  localparam int DEFAULT_N = 4;

  // Worst-case engine run time for an n x n product plus slack.
  function automatic int default_timeout(input int n);
    return n * n * (n + 1) + 16;
  endfunction

endpackage

// File: rtl/matmul_job_arbiter_rr_pick.sv
// Combinational round-robin pick: first unmasked request at or after ptr_i, wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o,
  output logic [NUM_REQ-1:0] onehot_o
);

  logic [IW-1:0] cand;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = '0;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[cand] && !mask_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    onehot_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/matmul_job_arbiter.sv
// Round-robin owner of a shared start/done matrix engine with a run-time watchdog.
module matmul_job_arbiter
  import matmul_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int N       = DEFAULT_N,
  parameter  int TIMEOUT = default_timeout(N),
  localparam int IW      = $clog2(NUM_REQ),
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      sel,
  output logic               eng_start,
  input  logic               eng_done,
  output logic [NUM_REQ-1:0] req_done,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic               eng_start_q, eng_start_d;
  logic [NUM_REQ-1:0] req_done_q, req_done_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [IW-1:0]      owner_inc;
  logic [IW-1:0]      pick_ptr;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  // sel_q holds the owner for the whole job, so it doubles as the owner index.
  assign owner_inc = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
  assign pick_ptr  = (state_q == ARB_RELEASE) ? owner_inc : rr_ptr_q;
  assign pick_mask = (state_q == ARB_RELEASE) ? gnt_q : '0;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req),
    .mask_i   (pick_mask),
    .ptr_i    (pick_ptr),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    eng_start_d = 1'b0;
    req_done_d  = '0;
    err_d       = err_clr ? 1'b0 : err_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d     = ARB_GRANT;
          gnt_d       = pick_onehot;
          sel_d       = pick_idx;
          eng_start_d = 1'b1;
        end
      end
      ARB_GRANT: begin
        timer_d = '0;
        state_d = ARB_RUN;
      end
      ARB_RUN: begin
        timer_d = timer_q + 1'b1;
        if (eng_done) begin
          state_d    = ARB_RELEASE;
          req_done_d = gnt_q;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d    = ARB_ABORT;
          req_done_d = gnt_q;
        end
      end
      ARB_RELEASE: begin
        rr_ptr_d = owner_inc;
        if (pick_valid) begin
          state_d     = ARB_GRANT;
          gnt_d       = pick_onehot;
          sel_d       = pick_idx;
          eng_start_d = 1'b1;
        end else begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          sel_d   = '0;
        end
      end
      ARB_ABORT: begin
        err_d    = 1'b1;
        rr_ptr_d = owner_inc;
        state_d  = ARB_IDLE;
        gnt_d    = '0;
        sel_d    = '0;
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        sel_d   = '0;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      timer_q     <= '0;
      gnt_q       <= '0;
      sel_q       <= '0;
      eng_start_q <= 1'b0;
      req_done_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      eng_start_q <= eng_start_d;
      req_done_q  <= req_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign eng_start = eng_start_q;
  assign req_done  = req_done_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Arbiter bench: a behavioural 4x4 engine steered by sel, scoreboarded job completions.
module tb_matmul_job_arbiter;

  typedef logic [15:0][15:0] mat_t;
  typedef struct packed {
    logic [1:0] owner;
    mat_t       c;
  } exp_t;
  typedef struct packed {
    logic [3:0][3:0] jobs;
    logic [3:0]      n;
    logic [7:0][1:0] owners;
    logic [7:0]      lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: default watchdog, driven by the engine model.
  logic [3:0] req, gnt, req_done;
  logic [1:0] sel;
  logic       eng_start, eng_done, busy, err, err_clr;
  logic       eng_done_model, eng_done_force;
  assign eng_done = eng_done_model | eng_done_force;

  // Instance B: short watchdog, driven directly.
  logic [3:0] req_b, gnt_b, req_done_b;
  logic [1:0] sel_b;
  logic       eng_start_b, eng_done_b, busy_b, err_b, err_clr_b;

  matmul_job_arbiter #(.NUM_REQ(4), .N(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .sel(sel),
    .eng_start(eng_start), .eng_done(eng_done), .req_done(req_done),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  matmul_job_arbiter #(.NUM_REQ(4), .N(4), .TIMEOUT(8)) u_dut_to (
    .clk(clk), .reset(reset), .req(req_b), .gnt(gnt_b), .sel(sel_b),
    .eng_start(eng_start_b), .eng_done(eng_done_b), .req_done(req_done_b),
    .busy(busy_b), .err(err_b), .err_clr(err_clr_b)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   jobs_left [4];
  logic [3:0] drop_mask;
  mat_t mat_a [4], mat_b [4], mat_c [4];
  exp_t sb_q [$];
  int   eng_lat, n_starts;
  logic eng_auto;

  always_comb begin
    for (int i = 0; i < 4; i++) req[i] = (jobs_left[i] != 0) && !drop_mask[i];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t c;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++) begin
        c[r*4+cc] = '0;
        for (int k = 0; k < 4; k++) c[r*4+cc] += a[r*4+k] * b[k*4+cc];
      end
    return c;
  endfunction

  task automatic push_exp(input int owner);
    exp_t e;
    e.owner = owner[1:0];
    e.c     = matmul(mat_a[owner], mat_b[owner]);
    sb_q.push_back(e);
  endtask

  // Engine model plus monitor, all on the falling edge.
  initial begin
    int   cnt;
    logic pending;
    mat_t cap_a, cap_b;
    logic prev_start, prev_rd_any;
    logic [3:0] prev_pend;
    exp_t e;
    int   idx;
    pending = 0; cnt = 0; eng_done_model = 0;
    prev_start = 0; prev_rd_any = 0; prev_pend = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 0; eng_done_model = 0;
        prev_start = 0; prev_rd_any = 0;
      end else begin
        chk("busy_vs_gnt", busy, |gnt);
        chk("gnt_onehot0", $onehot0(gnt), 1);
        chk("req_done_onehot0", $onehot0(req_done), 1);
        if (eng_start) begin
          n_starts++;
          chk("start_gnt_sel", gnt, 4'b1 << sel);
          chk("start_single", prev_start, 0);
        end
        if (prev_rd_any && prev_pend != 0) chk("no_idle_gap", eng_start, 1);
        if (req_done != 0) begin
          idx = 0;
          for (int i = 0; i < 4; i++) if (req_done[i]) idx = i;
          chk("done_latency", eng_done, 1);
          if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb_q.pop_front();
            chk("done_owner", idx, e.owner);
            chk("result_c", mat_c[e.owner] == e.c, 1);
            $display("job owner=%0d c33=%0d", idx, mat_c[idx][15]);
          end
          if (jobs_left[idx] > 0) jobs_left[idx]--;
        end
        prev_start  = eng_start;
        prev_rd_any = (req_done != 0);
        prev_pend   = req & ~req_done;

        eng_done_model = 0;
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            eng_done_model = 1;
            pending = 0;
            mat_c[sel] = matmul(cap_a, cap_b);
          end
        end
        if (eng_start && eng_auto) begin
          pending = 1; cnt = eng_lat;
          cap_a = mat_a[sel]; cap_b = mat_b[sel];
        end
      end
    end
  end

  task automatic wait_idle(input string nm, input int budget);
    logic ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      ok = (sb_q.size() == 0) && !busy && (jobs_left[0] + jobs_left[1] + jobs_left[2] + jobs_left[3] == 0);
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_start_b(input string nm);
    logic ok;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      ok = eng_start_b;
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  vec_t tbl [5];

  initial begin
    int s0, k;
    logic ok;
    tbl[0] = '{jobs: {4'd1, 4'd1, 4'd1, 4'd2}, n: 4'd5,
               owners: {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, lat: 8'd3};
    tbl[1] = '{jobs: {4'd0, 4'd1, 4'd0, 4'd1}, n: 4'd2,
               owners: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2}, lat: 8'd5};
    tbl[2] = '{jobs: {4'd0, 4'd0, 4'd0, 4'd1}, n: 4'd1,
               owners: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, lat: 8'd81};
    tbl[3] = '{jobs: {4'd0, 4'd0, 4'd1, 4'd1}, n: 4'd2,
               owners: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, lat: 8'd2};
    tbl[4] = '{jobs: {4'd1, 4'd0, 4'd1, 4'd0}, n: 4'd2,
               owners: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1}, lat: 8'd1};

    for (int i = 0; i < 4; i++) begin
      jobs_left[i] = 0;
      mat_c[i] = '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          mat_a[i][r*4+c] = 16'(r*4 + c + i*3);
          mat_b[i][r*4+c] = 16'(c*4 + r + i);
        end
    end
    drop_mask = '0; eng_done_force = 0; err_clr = 0; eng_auto = 1; eng_lat = 3; n_starts = 0;
    req_b = '0; eng_done_b = 0; err_clr_b = 0;

    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);   chk("rst_sel", sel, 0);  chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);   chk("rst_start", eng_start, 0); chk("rst_done", req_done, 0);
    reset = 0;

    // Reset while owner 2 is running.
    eng_auto = 0;
    @(posedge clk); #1;
    jobs_left[2] = 1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(posedge clk); #1; ok = eng_start; end
    chk("t1_grant2", ok && gnt == 4'b0100, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_running", busy, 1);
    reset = 1;
    @(negedge clk);
    chk("t1_gnt", gnt, 0); chk("t1_busy", busy, 0); chk("t1_done", req_done, 0);
    chk("t1_err", err, 0); chk("t1_start", eng_start, 0);
    jobs_left[2] = 0;
    @(posedge clk); #1;
    reset = 0; eng_auto = 1;

    foreach (tbl[v]) begin
      for (int j = 0; j < int'(tbl[v].n); j++) push_exp(int'(tbl[v].owners[j]));
      s0 = n_starts;
      eng_lat = int'(tbl[v].lat);
      for (int i = 0; i < 4; i++) jobs_left[i] = int'(tbl[v].jobs[i]);
      wait_idle($sformatf("vec%0d_complete", v), 600);
      chk($sformatf("vec%0d_starts", v), n_starts - s0, tbl[v].n);
      if (v == 2) chk("c33_req0", mat_c[0][15], 734);
    end

    // eng_done in IDLE is ignored.
    eng_done_force = 1;
    @(posedge clk); #1;
    eng_done_force = 0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_rd", req_done, 0);

    // eng_done in GRANT ignored; req dropped mid-run still completes.
    push_exp(2);
    eng_lat = 20;
    jobs_left[2] = 1;
    @(posedge clk); #1;
    chk("t6_in_grant", eng_start, 1);
    eng_done_force = 1;
    @(posedge clk); #1;
    eng_done_force = 0;
    @(posedge clk); #1;
    chk("t6_grant_done_ignored", busy && req_done == 0 && gnt == 4'b0100, 1);
    drop_mask = 4'b0100;
    wait_idle("t6_drop_complete", 100);
    drop_mask = '0;

    // Watchdog abort on the short-timeout instance.
    req_b = 4'b0001;
    wait_start_b("to_start");
    k = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #1; k++; ok = (req_done_b != 0); end
    chk("to_abort_cycles", k, 9);
    chk("to_abort_owner", req_done_b, 4'b0001);
    chk("to_err_pre", err_b, 0);
    err_clr_b = 1;
    req_b = '0;
    @(posedge clk); #1;
    err_clr_b = 0;
    chk("to_err_set_wins", err_b, 1);
    chk("to_idle", busy_b, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("to_err_sticky", err_b, 1);
    err_clr_b = 1;
    @(posedge clk); #1;
    err_clr_b = 0;
    chk("to_err_cleared", err_b, 0);

    // Done and timeout on the same cycle: normal release.
    req_b = 4'b0100;
    wait_start_b("to_regrant");
    chk("to_regrant_gnt", gnt_b, 4'b0100);
    chk("to_regrant_sel", sel_b, 2);
    repeat (8) @(posedge clk);
    #1;
    eng_done_b = 1;
    @(posedge clk); #1;
    eng_done_b = 0;
    chk("to_tie_done", req_done_b, 4'b0100);
    req_b = '0;
    @(posedge clk); #1;
    chk("to_tie_err", err_b, 0);
    chk("to_tie_idle", busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
